// File: rtl/vga_pkg.sv
// Shared VGA timing constants (640x480 @ 60 Hz defaults) and a window-test helper.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package vga_pkg;

   localparam int unsigned COORD_W = 10;

   // Default horizontal timing, in pixel clocks
   localparam int unsigned H_VIS_DEF   = 640;
   localparam int unsigned H_FP_DEF    = 16;
   localparam int unsigned H_SYNC_DEF  = 96;
   localparam int unsigned H_TOTAL_DEF = 800;

   // Default vertical timing, in lines
   localparam int unsigned V_VIS_DEF   = 480;
   localparam int unsigned V_FP_DEF    = 10;
   localparam int unsigned V_SYNC_DEF  = 2;
   localparam int unsigned V_TOTAL_DEF = 525;

   // Sync windows for the default timing, as half-open ranges [START, END)
   localparam int unsigned H_SYNC_START = H_VIS_DEF + H_FP_DEF;
   localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC_DEF;
   localparam int unsigned V_SYNC_START = V_VIS_DEF + V_FP_DEF;
   localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC_DEF;

   // Unsigned half-open window test: lo <= v < hi
   function automatic logic in_window(input logic [COORD_W-1:0] v,
                                      input logic [COORD_W-1:0] lo,
                                      input logic [COORD_W-1:0] hi);
      return (v >= lo) && (v < hi);
   endfunction

endpackage

// File: rtl/vcounter.sv
// Vertical line counter: advances once per trig_v, wraps at V_TOTAL-1 -> 0.
// Latency: v_next_o is combinational (row in effect this cycle); the count register lags by 1 clk.
// Backpressure: none; every trig_v cycle advances the count, including back-to-back pulses.
//   clk_i     pixel clock
//   rst_i     synchronous active-high reset, count -> 0
//   trig_v_i  end-of-line pulse from the horizontal counter
//   v_next_o  line number that applies in the current cycle
module vcounter
   import vga_pkg::*;
#(
   parameter int unsigned V_TOTAL = V_TOTAL_DEF,
   parameter int unsigned W       = COORD_W
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         trig_v_i,
   output logic [W-1:0] v_next_o
);

   localparam logic [W-1:0] V_LAST = W'(V_TOTAL - 1);

   logic [W-1:0] v_count_q;
   logic [W-1:0] v_count_d;

   always_comb begin
      v_count_d = v_count_q;
      if (trig_v_i) begin
         v_count_d = (v_count_q == V_LAST) ? '0 : v_count_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         v_count_q <= '0;
      end else begin
         v_count_q <= v_count_d;
      end
   end

   assign v_next_o = v_count_d;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA sync/timing generator fed by an upstream horizontal counter (h_count, trig_v).
// Latency: all outputs registered, 1 clk after the (h_count, trig_v) they reflect.
// Backpressure: none; free-running, one pixel per clk.
//   clk, rst          pixel clock, synchronous active-high reset
//   h_count, trig_v   horizontal position and end-of-line pulse from upstream
//   hsync, vsync      sync pulses, active level SYNC_POL
//   video_on, x, y    visible-window flag and pixel coordinates (0 when blank)
//   line_start        first pixel of each line; frame_start: pixel (0,0)
module vga_sync_gen
   import vga_pkg::*;
#(
   parameter int unsigned H_VIS    = H_VIS_DEF,
   parameter int unsigned H_FP     = H_FP_DEF,
   parameter int unsigned H_SYNC   = H_SYNC_DEF,
   parameter int unsigned H_TOTAL  = H_TOTAL_DEF,
   parameter int unsigned V_VIS    = V_VIS_DEF,
   parameter int unsigned V_FP     = V_FP_DEF,
   parameter int unsigned V_SYNC   = V_SYNC_DEF,
   parameter int unsigned V_TOTAL  = V_TOTAL_DEF,
   parameter logic        SYNC_POL = 1'b0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [COORD_W-1:0] h_count,
   input  logic               trig_v,
   output logic               hsync,
   output logic               vsync,
   output logic               video_on,
   output logic [COORD_W-1:0] x,
   output logic [COORD_W-1:0] y,
   output logic               line_start,
   output logic               frame_start
);

   localparam logic [COORD_W-1:0] H_VIS_L  = COORD_W'(H_VIS);
   localparam logic [COORD_W-1:0] H_TOT_L  = COORD_W'(H_TOTAL);
   localparam logic [COORD_W-1:0] V_VIS_L  = COORD_W'(V_VIS);
   localparam logic [COORD_W-1:0] HS_LO    = COORD_W'(H_VIS + H_FP);
   localparam logic [COORD_W-1:0] HS_HI    = COORD_W'(H_VIS + H_FP + H_SYNC);
   localparam logic [COORD_W-1:0] VS_LO    = COORD_W'(V_VIS + V_FP);
   localparam logic [COORD_W-1:0] VS_HI    = COORD_W'(V_VIS + V_FP + V_SYNC);

   // Row that applies this cycle: on the trig_v cycle this is already the new line
   logic [COORD_W-1:0] v_next;

   vcounter #(
      .V_TOTAL (V_TOTAL),
      .W       (COORD_W)
   ) u_vcnt (
      .clk_i    (clk),
      .rst_i    (rst),
      .trig_v_i (trig_v),
      .v_next_o (v_next)
   );

   logic               h_in_line;
   logic               h_act;
   logic               v_act;
   logic               hsync_d, vsync_d, video_on_d, line_start_d, frame_start_d;
   logic [COORD_W-1:0] x_d, y_d;
   logic               hsync_q, vsync_q, video_on_q, line_start_q, frame_start_q;
   logic [COORD_W-1:0] x_q, y_q;

   always_comb begin
      // h_count beyond the line length is plain blanking
      h_in_line     = (h_count < H_TOT_L);
      h_act         = h_in_line && in_window(h_count, HS_LO, HS_HI);
      v_act         = in_window(v_next, VS_LO, VS_HI);
      hsync_d       = h_act ? SYNC_POL : ~SYNC_POL;
      vsync_d       = v_act ? SYNC_POL : ~SYNC_POL;
      video_on_d    = (h_count < H_VIS_L) && (v_next < V_VIS_L);
      x_d           = video_on_d ? h_count : '0;
      y_d           = video_on_d ? v_next  : '0;
      line_start_d  = (h_count == '0);
      frame_start_d = (h_count == '0) && (v_next == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hsync_q       <= ~SYNC_POL;
         vsync_q       <= ~SYNC_POL;
         video_on_q    <= 1'b0;
         x_q           <= '0;
         y_q           <= '0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         video_on_q    <= video_on_d;
         x_q           <= x_d;
         y_q           <= y_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign video_on    = video_on_q;
   assign x           = x_q;
   assign y           = y_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench for vga_sync_gen: active-low and active-high builds driven in parallel.
// Latency: compares each output 1 clk after the inputs that produced it.
// Backpressure: n/a.
module tb_vga_sync_gen;

   localparam int H_VIS = 640, H_FP = 16, H_SYNC = 96, H_TOTAL = 800;
   localparam int V_VIS = 480, V_FP = 10, V_SYNC = 2,  V_TOTAL = 525;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [9:0] h_count = '0;
   logic       trig_v = 1'b0;

   logic       hs0, vs0, von0, ls0, fs0;
   logic [9:0] x0, y0;
   logic       hs1, vs1, von1, ls1, fs1;
   logic [9:0] x1, y1;

   always #5 clk = ~clk;

   vga_sync_gen #(.SYNC_POL(1'b0)) dut0 (
      .clk(clk), .rst(rst), .h_count(h_count), .trig_v(trig_v),
      .hsync(hs0), .vsync(vs0), .video_on(von0), .x(x0), .y(y0),
      .line_start(ls0), .frame_start(fs0)
   );

   vga_sync_gen #(.SYNC_POL(1'b1)) dut1 (
      .clk(clk), .rst(rst), .h_count(h_count), .trig_v(trig_v),
      .hsync(hs1), .vsync(vs1), .video_on(von1), .x(x1), .y(y1),
      .line_start(ls1), .frame_start(fs1)
   );

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   // Reference state: the line number currently in effect
   int mv = 0;

   // Event counters for whole-line / whole-frame properties
   int n_hs_lo, n_vs_lo, n_ls, n_fs, n_von;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @cycle %0d: got %0d, expected %0d", tag, cyc, got, exp);
      end
   endtask

   task automatic clr_counts();
      n_hs_lo = 0; n_vs_lo = 0; n_ls = 0; n_fs = 0; n_von = 0;
   endtask

   // Apply one cycle of stimulus, predict, then check all outputs of both builds
   task automatic step(input int h, input bit t, input bit r);
      int vn;
      bit e_hs_act, e_vs_act, e_von, e_ls, e_fs;
      int e_x, e_y;
      h_count = 10'(h);
      trig_v  = t;
      rst     = r;
      if (r) begin
         mv = 0;
         e_hs_act = 0; e_vs_act = 0; e_von = 0; e_ls = 0; e_fs = 0; e_x = 0; e_y = 0;
      end else begin
         vn       = t ? (mv + 1) % V_TOTAL : mv;
         e_hs_act = (h >= H_VIS + H_FP) && (h < H_VIS + H_FP + H_SYNC);
         e_vs_act = (vn >= V_VIS + V_FP) && (vn < V_VIS + V_FP + V_SYNC);
         e_von    = (h < H_VIS) && (vn < V_VIS);
         e_x      = e_von ? h : 0;
         e_y      = e_von ? vn : 0;
         e_ls     = (h == 0);
         e_fs     = (h == 0) && (vn == 0);
         mv       = vn;
      end
      @(posedge clk);
      #1;
      cyc++;
      chk("hsync_lo",    hs0,  !e_hs_act);
      chk("vsync_lo",    vs0,  !e_vs_act);
      chk("video_on",    von0, e_von);
      chk("x",           x0,   e_x);
      chk("y",           y0,   e_y);
      chk("line_start",  ls0,  e_ls);
      chk("frame_start", fs0,  e_fs);
      chk("hsync_hi",    hs1,  e_hs_act);
      chk("vsync_hi",    vs1,  e_vs_act);
      if (hs0 === 1'b0) n_hs_lo++;
      if (vs0 === 1'b0) n_vs_lo++;
      if (ls0 === 1'b1) n_ls++;
      if (fs0 === 1'b1) n_fs++;
      if (von0 === 1'b1) n_von++;
   endtask

   initial begin
      // Reset, then three full 800-clock lines with trig_v on each wrap
      step(0, 0, 1);
      clr_counts();
      for (int l = 0; l < 3; l++) begin
         for (int h = 0; h < H_TOTAL; h++) begin
            step(h, (h == 0) && (l > 0), 0);
            if (l == 1 && h == 0) chk("line2_y", y0, 1);
         end
      end
      chk("hsync_low_clks_3lines", n_hs_lo, 3 * H_SYNC);
      chk("line_start_count",      n_ls,    3);

      // One full frame of compressed 4-clock lines: sync spans whole lines
      clr_counts();
      for (int l = 0; l < V_TOTAL; l++) begin
         step(0, 1, 0);
         for (int k = 0; k < 3; k++) step($urandom_range(1, 1023), 0, 0);
      end
      chk("vsync_low_clks_frame", n_vs_lo, V_SYNC * 4);
      chk("frame_start_count",    n_fs,    1);

      // Random h (including >= H_TOTAL), random trig_v anywhere, occasional reset
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 1023), ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 199) == 0));
      end

      // Reset at h=700 on line 300 (reached with trig_v held high)
      step(5, 0, 1);
      repeat (300) step(5, 1, 0);
      step(700, 0, 1);
      chk("rst_v_count", dut0.u_vcnt.v_count_q, 0);
      step(0, 1, 0);
      chk("rst_then_y", y0, 1);
      chk("rst_then_video", von0, 1);

      // Visible boundary on row 479, then row 480 shows nothing
      step(900, 0, 1);
      repeat (479) step(900, 1, 0);
      step(639, 0, 0);
      chk("x_last_col", x0, 639);
      chk("von_last_col", von0, 1);
      step(640, 0, 0);
      chk("von_past_col", von0, 0);
      clr_counts();
      step(0, 1, 0);
      for (int h = 1; h < H_TOTAL; h++) step(h, 0, 0);
      chk("row480_video_count", n_von, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
